// File: rtl/packet_rr_arbiter_if.sv
// packet_rr_arbiter_if: upstream packet lanes and the shared downstream stream of the arbiter.
interface packet_rr_arbiter_if #(
  parameter int width = 8,
  parameter int n_inputs = 4
);
  logic [n_inputs-1:0] up_valid, up_ready, up_last, grant;
  logic [n_inputs*width-1:0] up_data;
  logic down_valid, down_ready, down_first, down_last, busy;
  logic [width-1:0] down_data;
  modport master (
    input  up_valid, up_last, up_data, down_ready,
    output up_ready, down_valid, down_first, down_last, down_data, grant, busy
  );
  modport slave (
    output up_valid, up_last, up_data, down_ready,
    input  up_ready, down_valid, down_first, down_last, down_data, grant, busy
  );
endinterface

// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: packet-atomic round-robin mux of n_inputs streams onto one framed stream.
module packet_rr_arbiter #(
  parameter int width = 8,
  parameter int n_inputs = 4
) (
  input logic clock,
  input logic reset,
  packet_rr_arbiter_if.master bus_io
);
  localparam int pw = $clog2(n_inputs);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [n_inputs-1:0] grant_q, grant_d;
  logic [pw-1:0] rr_ptr_q, rr_ptr_d, pick, idx, g_idx;
  logic first_q, first_d, accept;
  // Scanning from the farthest offset down leaves the nearest requester at or after rr_ptr in pick.
  always_comb begin
    pick = rr_ptr_q;
    idx = '0;
    g_idx = '0;
    for (int k = n_inputs - 1; k >= 0; k--) begin
      idx = pw'((int'(rr_ptr_q) + k) % n_inputs);
      if (bus_io.up_valid[idx]) pick = idx;
    end
    for (int k = 0; k < n_inputs; k++) if (grant_q[k]) g_idx = pw'(k);
  end
  always_comb begin
    bus_io.down_data = '0;
    for (int k = 0; k < n_inputs; k++) if (grant_q[k]) bus_io.down_data = bus_io.up_data[k*width +: width];
  end
  assign bus_io.down_valid = |(grant_q & bus_io.up_valid);
  assign bus_io.down_last = |(grant_q & bus_io.up_last);
  assign bus_io.down_first = first_q & bus_io.down_valid;
  assign bus_io.up_ready = grant_q & {n_inputs{bus_io.down_ready}};
  assign bus_io.grant = grant_q;
  assign bus_io.busy = state_q == BUSY;
  assign accept = bus_io.down_valid & bus_io.down_ready;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    first_d = first_q;
    if (state_q == IDLE) begin
      if (|bus_io.up_valid) begin
        state_d = BUSY;
        grant_d = {{(n_inputs-1){1'b0}}, 1'b1} << pick;
        first_d = 1'b1;
      end
    end else if (accept) begin
      first_d = 1'b0;
      if (bus_io.down_last) begin
        state_d = IDLE;
        grant_d = '0;
        rr_ptr_d = (g_idx == pw'(n_inputs - 1)) ? '0 : g_idx + 1'b1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q <= first_d;
    end
  end
endmodule

// File: tb/tb_packet_rr_arbiter.sv
// tb_packet_rr_arbiter: directed scenarios for the packet round-robin arbiter.
module tb_packet_rr_arbiter;
  localparam int W = 8, N = 4;
  logic clock = 1'b0, reset = 1'b1;
  int checks = 0, errors = 0;
  packet_rr_arbiter_if #(.width(W), .n_inputs(N)) bus ();
  packet_rr_arbiter #(.width(W), .n_inputs(N)) dut (.clock(clock), .reset(reset), .bus_io(bus));
  always #5 clock = ~clock;
  task automatic next_cycle;
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input int p, input logic v, input logic l, input logic [W-1:0] d);
    bus.up_valid[p] = v;
    bus.up_last[p] = l;
    bus.up_data[p*W +: W] = d;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.up_valid = '0;
    bus.up_last = '0;
    bus.up_data = '0;
    bus.down_ready = 1'b1;
    next_cycle;
    next_cycle;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.down_valid, bus.grant, bus.busy, bus.up_ready, bus.down_first, bus.down_last} !== 12'h000) begin
        $display("FAIL reset_idle c%0d: got v=%b g=%b busy=%b rdy=%b f=%b l=%b, want all 0", i,
                 bus.down_valid, bus.grant, bus.busy, bus.up_ready, bus.down_first, bus.down_last);
        errors++;
      end
      next_cycle;
    end
  endtask
  task automatic test_single_packet;
    logic [W-1:0] ed;
    do_reset;
    drive(1, 1'b1, 1'b0, 8'hA0);
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0000 || bus.down_valid !== 1'b0) begin
      $display("FAIL sp_req_cycle: got g=%b v=%b, want g=0000 v=0", bus.grant, bus.down_valid);
      errors++;
    end
    next_cycle;
    for (int b = 0; b < 3; b++) begin
      ed = 8'hA0 + 8'(b);
      drive(1, 1'b1, b == 2, ed);
      @(negedge clock);
      checks++;
      if (bus.grant !== 4'b0010 || bus.up_ready !== 4'b0010) begin
        $display("FAIL sp_grant b%0d: got g=%b rdy=%b, want 0010/0010", b, bus.grant, bus.up_ready);
        errors++;
      end
      checks++;
      if ({bus.down_valid, bus.down_first, bus.down_last, bus.down_data} !== {1'b1, b == 0, b == 2, ed}) begin
        $display("FAIL sp_beat b%0d: got v=%b f=%b l=%b d=%h, want v=1 f=%b l=%b d=%h", b,
                 bus.down_valid, bus.down_first, bus.down_last, bus.down_data, b == 0, b == 2, ed);
        errors++;
      end
      next_cycle;
    end
    drive(1, 1'b0, 1'b0, 8'h00);
    drive(0, 1'b1, 1'b1, 8'h01);
    drive(2, 1'b1, 1'b1, 8'h21);
    drive(3, 1'b1, 1'b1, 8'h31);
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.down_valid !== 1'b0) begin
      $display("FAIL sp_gap: got busy=%b g=%b v=%b, want 0/0000/0", bus.busy, bus.grant, bus.down_valid);
      errors++;
    end
    next_cycle;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0100 || bus.down_data !== 8'h21) begin
      $display("FAIL sp_rr_next: got g=%b d=%h, want g=0100 d=21", bus.grant, bus.down_data);
      errors++;
    end
    next_cycle;
    bus.up_valid = '0;
  endtask
  task automatic test_all_ports;
    logic [W-1:0] exp_d[8] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
    int exp_c[8] = '{1, 2, 4, 5, 7, 8, 10, 11};
    int beat[N] = '{default: 0};
    logic acc[N];
    int idx = 0;
    do_reset;
    for (int cyc = 0; cyc < 14; cyc++) begin
      for (int p = 0; p < N; p++)
        if (beat[p] < 2) drive(p, 1'b1, beat[p] == 1, 8'(16 * p + beat[p]));
        else drive(p, 1'b0, 1'b0, 8'h00);
      @(negedge clock);
      if (bus.down_valid && bus.down_ready) begin
        checks++;
        if (idx >= 8) begin
          $display("FAIL all_extra_beat: got d=%h at c%0d, want no beat", bus.down_data, cyc);
          errors++;
        end else if (bus.down_data !== exp_d[idx] || cyc != exp_c[idx] ||
                     bus.down_first !== (idx % 2 == 0) || bus.down_last !== (idx % 2 == 1)) begin
          $display("FAIL all_beat%0d: got d=%h c%0d f=%b l=%b, want d=%h c%0d f=%b l=%b", idx,
                   bus.down_data, cyc, bus.down_first, bus.down_last, exp_d[idx], exp_c[idx],
                   idx % 2 == 0, idx % 2 == 1);
          errors++;
        end
        idx++;
      end
      for (int p = 0; p < N; p++) acc[p] = bus.up_ready[p] & bus.up_valid[p];
      next_cycle;
      for (int p = 0; p < N; p++) if (acc[p]) beat[p]++;
    end
    checks++;
    if (idx != 8) begin
      $display("FAIL all_count: got %0d beats, want 8", idx);
      errors++;
    end
  endtask
  task automatic test_stall;
    do_reset;
    drive(2, 1'b1, 1'b0, 8'h20);
    @(negedge clock);
    next_cycle;
    @(negedge clock);
    checks++;
    if ({bus.grant, bus.down_valid, bus.down_first, bus.down_data} !== {4'b0100, 1'b1, 1'b1, 8'h20}) begin
      $display("FAIL stall_first: got g=%b v=%b f=%b d=%h, want 0100/1/1/20",
               bus.grant, bus.down_valid, bus.down_first, bus.down_data);
      errors++;
    end
    next_cycle;
    drive(2, 1'b0, 1'b0, 8'h21);
    drive(0, 1'b1, 1'b1, 8'h05);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus.grant !== 4'b0100 || bus.down_valid !== 1'b0 || bus.up_ready !== 4'b0100) begin
        $display("FAIL stall_bubble c%0d: got g=%b v=%b rdy=%b, want 0100/0/0100", i,
                 bus.grant, bus.down_valid, bus.up_ready);
        errors++;
      end
      next_cycle;
    end
    for (int b = 1; b < 3; b++) begin
      drive(2, 1'b1, b == 2, 8'h20 + 8'(b));
      @(negedge clock);
      checks++;
      if ({bus.down_valid, bus.down_first, bus.down_last, bus.down_data, bus.up_ready} !==
          {1'b1, 1'b0, b == 2, 8'h20 + 8'(b), 4'b0100}) begin
        $display("FAIL stall_resume b%0d: got v=%b f=%b l=%b d=%h rdy=%b, want 1/0/%b/%h/0100", b,
                 bus.down_valid, bus.down_first, bus.down_last, bus.down_data, bus.up_ready,
                 b == 2, 8'h20 + 8'(b));
        errors++;
      end
      next_cycle;
    end
    drive(2, 1'b0, 1'b0, 8'h00);
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      $display("FAIL stall_gap: got g=%b busy=%b, want 0000/0", bus.grant, bus.busy);
      errors++;
    end
    next_cycle;
    @(negedge clock);
    checks++;
    if ({bus.grant, bus.down_first, bus.down_last, bus.down_data} !== {4'b0001, 1'b1, 1'b1, 8'h05}) begin
      $display("FAIL stall_next: got g=%b f=%b l=%b d=%h, want 0001/1/1/05",
               bus.grant, bus.down_first, bus.down_last, bus.down_data);
      errors++;
    end
    next_cycle;
    drive(0, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic test_backpressure;
    bit rdy[8] = '{0, 1, 0, 0, 1, 1, 0, 1};
    logic [W-1:0] ed[8] = '{8'hB0, 8'hB0, 8'hB1, 8'hB1, 8'hB1, 8'hB2, 8'hB3, 8'hB3};
    logic ef[8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic el[8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int beat = 0;
    logic acc;
    do_reset;
    drive(1, 1'b1, 1'b0, 8'hB0);
    @(negedge clock);
    next_cycle;
    for (int k = 0; k < 8; k++) begin
      drive(1, 1'b1, beat == 3, 8'hB0 + 8'(beat));
      bus.down_ready = rdy[k];
      @(negedge clock);
      checks++;
      if ({bus.down_valid, bus.down_first, bus.down_last, bus.down_data} !== {1'b1, ef[k], el[k], ed[k]}) begin
        $display("FAIL bp_beat k%0d: got v=%b f=%b l=%b d=%h, want 1/%b/%b/%h", k,
                 bus.down_valid, bus.down_first, bus.down_last, bus.down_data, ef[k], el[k], ed[k]);
        errors++;
      end
      acc = bus.up_ready[1];
      next_cycle;
      if (acc) beat++;
    end
    drive(1, 1'b0, 1'b0, 8'h00);
    bus.down_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || beat != 4) begin
      $display("FAIL bp_done: got busy=%b g=%b accepted=%0d, want 0/0000/4", bus.busy, bus.grant, beat);
      errors++;
    end
    next_cycle;
  endtask
  task automatic test_reset_mid;
    do_reset;
    drive(3, 1'b1, 1'b0, 8'hD0);
    @(negedge clock);
    next_cycle;
    for (int b = 0; b < 3; b++) begin
      drive(3, 1'b1, 1'b0, 8'hD0 + 8'(b));
      if (b == 2) reset = 1'b1;
      @(negedge clock);
      checks++;
      if (bus.grant !== 4'b1000 || bus.down_data !== 8'hD0 + 8'(b) || bus.down_first !== (b == 0)) begin
        $display("FAIL rst_beat b%0d: got g=%b d=%h f=%b, want 1000/%h/%b", b,
                 bus.grant, bus.down_data, bus.down_first, 8'hD0 + 8'(b), b == 0);
        errors++;
      end
      next_cycle;
    end
    reset = 1'b0;
    drive(3, 1'b1, 1'b0, 8'hE0);
    @(negedge clock);
    checks++;
    if ({bus.down_valid, bus.grant, bus.busy, bus.up_ready, bus.down_first, bus.down_last} !== 12'h000) begin
      $display("FAIL rst_clear: got v=%b g=%b busy=%b rdy=%b f=%b l=%b, want all 0",
               bus.down_valid, bus.grant, bus.busy, bus.up_ready, bus.down_first, bus.down_last);
      errors++;
    end
    next_cycle;
    @(negedge clock);
    checks++;
    if ({bus.grant, bus.down_valid, bus.down_first, bus.down_data} !== {4'b1000, 1'b1, 1'b1, 8'hE0}) begin
      $display("FAIL rst_restart: got g=%b v=%b f=%b d=%h, want 1000/1/1/e0",
               bus.grant, bus.down_valid, bus.down_first, bus.down_data);
      errors++;
    end
    next_cycle;
    bus.up_valid = '0;
  endtask
  initial begin
    test_reset;
    test_single_packet;
    test_all_ports;
    test_stall;
    test_backpressure;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_rr_arbiter.md
# packet_rr_arbiter

- Shares one downstream valid/ready stream among `n_inputs` upstream packet streams.
- Grants are packet-atomic and round-robin: once a port wins, it owns the output until its `last` beat is accepted.
- Adds `down_first` framing on the first beat of each packet, so downstream first/last converters and packet sinks see clean frame markers.
- Sits between per-source packet producers and a single shared packet consumer.

## Interface

Parameters:
- `width`, default 8: data width per beat.
- `n_inputs`, default 4: number of requesters, range 2..16.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `up_valid`  in  n_inputs  per-port beat valid.
- `up_ready`  out  n_inputs  per-port beat accept.
- `up_last`  in  n_inputs  per-port last beat of packet.
- `up_data`  in  n_inputs*width  port i at bits [i*width +: width].
- `down_valid`  out  1  output beat valid.
- `down_ready`  in  1  downstream accept.
- `down_first`  out  1  first beat of a packet.
- `down_last`  out  1  last beat of a packet.
- `down_data`  out  width  output beat data.
- `grant`  out  n_inputs  one-hot owner of the output; all-zero when idle.
- `busy`  out  1  a packet is in progress (state BUSY).

## Operation

- FSM states: IDLE, BUSY. Registers: `state`, `grant` (one-hot), `rr_ptr` (index of highest-priority port), `first_pending`.
- IDLE, some `up_valid` high:
  - Pick the first requesting port scanning `rr_ptr`, `rr_ptr`+1, …, with wrap modulo `n_inputs`.
  - Next cycle: `grant` = that port, state = BUSY, `first_pending` = 1.
- IDLE, no `up_valid` high: stay in IDLE, `grant` = 0.
- BUSY, granted port g:
  - `down_valid` = `up_valid[g]`, `down_data` = data of port g, `down_last` = `up_last[g]`.
  - `down_first` = `first_pending` & `down_valid`.
  - `up_ready[g]` = `down_ready`; all other `up_ready` bits = 0.
- A beat is accepted when `down_valid` & `down_ready`. Accepting a beat clears `first_pending`.
- Accepted beat with `down_last` = 1:
  - next cycle state = IDLE, `grant` = 0.
  - `rr_ptr` = (g+1) mod `n_inputs`.
- In IDLE, `up_ready` = 0 and `down_valid`/`down_first`/`down_last` = 0. `down_data` is don't-care; drive 0.
- Width rules: `rr_ptr` is $clog2(`n_inputs`) bits. Wrap at `n_inputs`-1 → 0, including non-power-of-two `n_inputs`.

## Timing

- Reset values: state IDLE, `grant` 0, `rr_ptr` 0, `first_pending` 0, `busy` 0. All outputs 0.
- Arbitration latency:
  - 1 cycle from a request in IDLE to `grant`/`down_valid` in BUSY.
  - The first beat can be accepted in the cycle after the request.
- Packet-to-packet gap: exactly 1 idle cycle after an accepted `last` beat, even when other ports are requesting.
- Data path in BUSY is combinational (valid, data, last, ready); there is no added latency per beat.
- Boundary conditions:
  - Granted port drops `up_valid` mid-packet: grant held, `down_valid` = 0 (bubble). No other port may be granted.
  - Single-beat packet: `down_first` = `down_last` = 1 on the same beat; back to IDLE next cycle.
  - `down_ready` = 0 with `down_valid` = 1: all outputs hold stable, including `down_first`.
  - Non-granted ports keep `up_valid` high: never accepted; their `up_ready` stays 0.
  - Simultaneous requests from all ports: served in order `rr_ptr`, `rr_ptr`+1, … ; each port gets exactly one packet per rotation.
  - `reset` mid-packet: next cycle returns to reset values. The partial packet is abandoned without a `last` beat.
  - `rr_ptr` changes only on an accepted `last` beat.

## Test plan

- Reset, then idle (`up_valid` = 0): `down_valid`, `grant`, `busy`, `up_ready` all 0 for 10 cycles.
- Port 1 sends a 3-beat packet A0, A1, A2 (last on A2), `down_ready` = 1:
  - `grant` = 4'b0010 one cycle after the request.
  - `down_first` on A0 only, `down_last` on A2 only.
  - IDLE after A2; `rr_ptr` = 2.
- All 4 ports request 2-beat packets simultaneously from reset: output packet order is ports 0, 1, 2, 3, with one idle cycle between packets.
- Port 2 granted; it deasserts `up_valid` for 3 cycles mid-packet while port 0 requests: port 2 resumes and finishes before port 0 is granted; `up_ready[0]` stays 0 throughout.
- Backpressure: `down_ready` toggles 1,0,0,1 during a 4-beat packet: no beat lost or duplicated; `down_first` held until the first beat is accepted.
- `reset` asserted on beat 2 of a 4-beat packet from port 3: outputs 0 next cycle. After release, a new request from port 3 is granted with `rr_ptr` = 0 and `down_first` = 1.
